// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman encoder phase sequencer.
//   huff_st_t      : sequencer state encoding
//   HUFF_NSYM      : number of symbols handled by the encoder pipeline
//   HUFF_TIMEOUT   : default per-phase watchdog budget in cycles
//   huff_is_phase(): true for the states where a sub-block is working and the watchdog runs
package huff_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCount  = 3'd1,
    StOrder  = 3'd2,
    StComb   = 3'd3,
    StDecode = 3'd4,
    StDone   = 3'd5,
    StErr    = 3'd6
  } huff_st_t;

  localparam int unsigned HUFF_NSYM    = 6;
  localparam int unsigned HUFF_TIMEOUT = 200;

  function automatic logic huff_is_phase(huff_st_t st);
    return (st == StOrder) || (st == StComb) || (st == StDecode);
  endfunction

endpackage

// File: rtl/huff_seq_ctrl_if.sv
// Handshake bundle between the phase sequencer and the encoder pipeline.
// master : sequencer side (drives starts, valids, grants, mem_sel, busy, err)
// slave  : pipeline side (drives gray_valid, done strobes, memory requests)
interface huff_seq_ctrl_if;
  import huff_pkg::*;

  logic gray_valid;
  logic cnt_en;
  logic cnt_clr;
  logic CNT_valid;
  logic ord_start;
  logic ord_done;
  logic cmb_start;
  logic mem_clear;
  logic cmb_done;
  logic dec_start;
  logic dec_done;
  logic code_valid;
  logic cmb_req;
  logic cmb_gnt;
  logic dec_req;
  logic dec_gnt;
  logic mem_sel;
  logic busy;
  logic err;

  modport master (
    input  gray_valid, ord_done, cmb_done, dec_done, cmb_req, dec_req,
    output cnt_en, cnt_clr, CNT_valid, ord_start, cmb_start, mem_clear, dec_start,
           code_valid, cmb_gnt, dec_gnt, mem_sel, busy, err
  );

  modport slave (
    output gray_valid, ord_done, cmb_done, dec_done, cmb_req, dec_req,
    input  cnt_en, cnt_clr, CNT_valid, ord_start, cmb_start, mem_clear, dec_start,
           code_valid, cmb_gnt, dec_gnt, mem_sel, busy, err
  );

endinterface

// File: rtl/huff_wdog.sv
// Per-phase watchdog counter.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clr        : restart the count (state entry)
//   en         : count this cycle (a sub-block phase is active)
//   expired    : the phase has used its last allowed cycle
module huff_wdog
  import huff_pkg::*;
#(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = HUFF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt_q;

  assign expired = en && (cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

endmodule

// File: rtl/huff_seq_ctrl.sv
// Phase sequencer and tree-memory arbiter for the Huffman encoder.
// Detects the grey-pixel burst, then walks count -> order -> combine -> decode, issuing
// one-cycle start pulses, CNT_valid and code_valid, and grants the shared tree memory to the
// combiner or decoder depending on the active phase. A stalled phase traps into a sticky error.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   bus        : huff_seq_ctrl_if master modport (pixel valid, counter controls, phase
//                start/done handshakes, memory request/grant, mem_sel, busy, err)
module huff_seq_ctrl
  import huff_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = HUFF_TIMEOUT
) (
  input logic             clk,
  input logic             reset,
  huff_seq_ctrl_if.master bus
);

  huff_st_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_max;
  logic             wdog_clr, wdog_en, wdog_exp;

  logic cnt_valid_q, ord_start_q, cmb_start_q, dec_start_q, code_valid_q;
  logic mem_sel_q, err_q;

  assign cnt_max = (cnt_q == {CNT_W{1'b1}});

  // Done strobes win over a coincident watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.gray_valid) state_d = StCount;
      end
      StCount: begin
        if (!bus.gray_valid) state_d = StOrder;
        else if (cnt_max)    state_d = StErr;
      end
      StOrder: begin
        if (bus.ord_done)  state_d = StComb;
        else if (wdog_exp) state_d = StErr;
      end
      StComb: begin
        if (bus.cmb_done)  state_d = StDecode;
        else if (wdog_exp) state_d = StErr;
      end
      StDecode: begin
        if (bus.dec_done)  state_d = StDone;
        else if (wdog_exp) state_d = StErr;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  assign wdog_clr = (state_d != state_q);
  assign wdog_en  = huff_is_phase(state_q);

  huff_wdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_exp)
  );

  // State, sample counter and registered outputs. Pulses are derived from the next state so
  // they line up with the first cycle of the phase they announce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cnt_valid_q  <= 1'b0;
      ord_start_q  <= 1'b0;
      cmb_start_q  <= 1'b0;
      dec_start_q  <= 1'b0;
      code_valid_q <= 1'b0;
      mem_sel_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;

      // The accepting pixel in IDLE is the first sample.
      if (state_q == StIdle && bus.gray_valid) begin
        cnt_q <= CNT_W'(1);
      end else if (state_q == StCount && bus.gray_valid && !cnt_max) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      cnt_valid_q  <= (state_d == StOrder)  && (state_q != StOrder);
      ord_start_q  <= (state_d == StOrder)  && (state_q != StOrder);
      cmb_start_q  <= (state_d == StComb)   && (state_q != StComb);
      dec_start_q  <= (state_d == StDecode) && (state_q != StDecode);
      code_valid_q <= (state_d == StDone);
      mem_sel_q    <= (state_d == StDecode) || (state_d == StDone);
      err_q        <= (state_d == StErr);
    end
  end

  assign bus.CNT_valid  = cnt_valid_q;
  assign bus.ord_start  = ord_start_q;
  assign bus.cmb_start  = cmb_start_q;
  assign bus.mem_clear  = cmb_start_q;
  assign bus.dec_start  = dec_start_q;
  assign bus.code_valid = code_valid_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.err        = err_q;

  assign bus.cnt_en  = bus.gray_valid && ((state_q == StIdle) || (state_q == StCount));
  assign bus.cnt_clr = bus.gray_valid && (state_q == StIdle);
  assign bus.busy    = (state_q != StIdle);

  // Grants follow the live state so they drop the instant reset is asserted.
  assign bus.cmb_gnt = bus.cmb_req && (state_q == StComb);
  assign bus.dec_gnt = bus.dec_req && ((state_q == StDecode) || (state_q == StDone));

endmodule

// File: tb/tb_huff_seq_ctrl.sv
module tb_huff_seq_ctrl;
  import huff_pkg::*;

  localparam int TO      = 200;
  localparam int EV_ORD  = 1;
  localparam int EV_CMB  = 2;
  localparam int EV_DEC  = 3;
  localparam int EV_CODE = 4;
  localparam int EV_ERR  = 5;

  typedef struct {
    int tag;
    int cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic gv = 1'b0, od_r = 1'b0, cd_r = 1'b0, dd_r = 1'b0;
  logic creq = 1'b0, dreq = 1'b0, dsel = 1'b0;
  int   cyc = 0;
  int   total = 0, bad = 0;
  ev_t  sb[$];

  int n_cnt_en = 0, n_cnt_clr = 0, n_cmb_gnt = 0, n_dec_gnt = 0, n_mem_sel = 0, n_both = 0;
  int cg_rise = -1, dg_rise = -1, ms_rise = -1;

  huff_seq_ctrl_if bus1 ();
  huff_seq_ctrl_if bus2 ();

  assign bus1.gray_valid = gv && !dsel;
  assign bus1.ord_done   = od_r && !dsel;
  assign bus1.cmb_done   = cd_r && !dsel;
  assign bus1.dec_done   = dd_r && !dsel;
  assign bus1.cmb_req    = creq && !dsel;
  assign bus1.dec_req    = dreq && !dsel;
  assign bus2.gray_valid = gv && dsel;
  assign bus2.ord_done   = od_r && dsel;
  assign bus2.cmb_done   = cd_r && dsel;
  assign bus2.dec_done   = dd_r && dsel;
  assign bus2.cmb_req    = creq && dsel;
  assign bus2.dec_req    = dreq && dsel;

  huff_seq_ctrl #(.CNT_W(8), .TO_W(8), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  huff_seq_ctrl #(.CNT_W(4), .TO_W(8), .TIMEOUT(TO)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {CNT_valid, ord_start, cmb_start, mem_clear, dec_start, code_valid,
  //  cmb_gnt, dec_gnt, mem_sel, busy, err, cnt_en, cnt_clr}
  function automatic logic [12:0] outs(input logic d);
    if (d) return {bus2.CNT_valid, bus2.ord_start, bus2.cmb_start, bus2.mem_clear,
                   bus2.dec_start, bus2.code_valid, bus2.cmb_gnt, bus2.dec_gnt, bus2.mem_sel,
                   bus2.busy, bus2.err, bus2.cnt_en, bus2.cnt_clr};
    return {bus1.CNT_valid, bus1.ord_start, bus1.cmb_start, bus1.mem_clear,
            bus1.dec_start, bus1.code_valid, bus1.cmb_gnt, bus1.dec_gnt, bus1.mem_sel,
            bus1.busy, bus1.err, bus1.cnt_en, bus1.cnt_clr};
  endfunction

  function automatic string ev_name(input int ev);
    case (ev)
      EV_ORD:  return "ord";
      EV_CMB:  return "cmb";
      EV_DEC:  return "dec";
      EV_CODE: return "code";
      default: return "err";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int ev, input int at, input logic d);
    ev_t e;
    e.tag = ev + (d ? 8 : 0);
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int ev, input logic both);
    ev_t e;
    int  tag;
    tag = ev + (dsel ? 8 : 0);
    check($sformatf("sb_pending_%s", ev_name(ev)), 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("sb_tag_%s", ev_name(ev)), tag, e.tag);
      check($sformatf("sb_cycle_%s", ev_name(ev)), cyc, e.cyc);
      if (ev == EV_ORD || ev == EV_CMB)
        check($sformatf("sb_paired_%s", ev_name(ev)), 32'(both), 32'd1);
    end
  endtask

  task automatic monitor();
    logic [12:0] o;
    logic er_prev = 1'b0, cg_prev = 1'b0, dg_prev = 1'b0, ms_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        er_prev = 1'b0; cg_prev = 1'b0; dg_prev = 1'b0; ms_prev = 1'b0;
      end else begin
        o = outs(dsel);
        if (o[1]) n_cnt_en++;
        if (o[0]) n_cnt_clr++;
        if (o[6]) n_cmb_gnt++;
        if (o[5]) n_dec_gnt++;
        if (o[4]) n_mem_sel++;
        if (o[6] && o[5]) n_both++;
        if (o[6] && !cg_prev) cg_rise = cyc;
        if (o[5] && !dg_prev) dg_rise = cyc;
        if (o[4] && !ms_prev) ms_rise = cyc;
        if (o[12] || o[11]) sb_pop(EV_ORD, o[12] && o[11]);
        if (o[10] || o[9])  sb_pop(EV_CMB, o[10] && o[9]);
        if (o[8])           sb_pop(EV_DEC, 1'b1);
        if (o[7])           sb_pop(EV_CODE, 1'b1);
        if (o[2] && !er_prev) sb_pop(EV_ERR, 1'b1);
        er_prev = o[2]; cg_prev = o[6]; dg_prev = o[5]; ms_prev = o[4];
      end
    end
  endtask

  // Drives one burst and the done strobes; od/cd/dd < 0 means that done never comes.
  // err_rel >= 0: ERR expected that many cycles after the start; -2: no events expected at all.
  task automatic run_flow(input logic d, input int npix, input int od, input int cd,
                          input int dd, input logic stray, input int len, input int err_rel);
    int c0, e, ec, ed, ef, lim;
    c0   = cyc;
    dsel = d;
    e    = c0 + npix + 1;
    ec   = (od >= 0) ? e + od + 1 : -1;
    ed   = (ec >= 0 && cd >= 0) ? ec + cd + 1 : -1;
    ef   = (ed >= 0 && dd >= 0) ? ed + dd + 1 : -1;
    if (err_rel == -2)     lim = c0;
    else if (err_rel >= 0) lim = c0 + err_rel;
    else                   lim = c0 + len;
    if (e < lim)              sb_push(EV_ORD, e, d);
    if (ec >= 0 && ec < lim) sb_push(EV_CMB, ec, d);
    if (ed >= 0 && ed < lim) sb_push(EV_DEC, ed, d);
    if (ef >= 0 && ef < lim) sb_push(EV_CODE, ef, d);
    if (err_rel >= 0)        sb_push(EV_ERR, c0 + err_rel, d);
    for (int k = 0; k < len; k++) begin
      gv   = (cyc < c0 + npix) || (stray && cyc == e + 1);
      od_r = (od >= 0) && (cyc == e + od);
      cd_r = (ec >= 0 && cd >= 0 && cyc == ec + cd) || (stray && cyc == e + 1);
      dd_r = (ed >= 0 && dd >= 0 && cyc == ed + dd) || (stray && cyc == e + 1);
      tick();
    end
    gv = 1'b0; od_r = 1'b0; cd_r = 1'b0; dd_r = 1'b0;
  endtask

  function automatic int fl(input int npix, input int od, input int cd, input int dd);
    return npix + od + cd + dd + 5;
  endfunction

  initial begin
    logic [12:0] o;
    int c0, b_en, b_clr, b_cg, b_dg, b_ms, b_both;

    fork
      monitor();
    join_none

    // Reset values
    repeat (3) tick();
    check("reset_outs_dut", 32'(outs(1'b0)), 32'd0);
    check("reset_outs_dut4", 32'(outs(1'b1)), 32'd0);
    reset = 1'b1;
    tick();

    // 100-pixel burst, done after 10/20/15, both requests held high
    creq = 1'b1; dreq = 1'b1;
    c0 = cyc;
    b_en = n_cnt_en; b_clr = n_cnt_clr; b_cg = n_cmb_gnt; b_dg = n_dec_gnt;
    b_ms = n_mem_sel; b_both = n_both;
    run_flow(1'b0, 100, 10, 20, 15, 1'b0, fl(100, 10, 20, 15), -1);
    check("s1_cnt_en", n_cnt_en - b_en, 100);
    check("s1_cnt_clr", n_cnt_clr - b_clr, 1);
    check("s1_cmb_gnt_cycles", n_cmb_gnt - b_cg, 21);
    check("s1_dec_gnt_cycles", n_dec_gnt - b_dg, 17);
    check("s1_mem_sel_cycles", n_mem_sel - b_ms, 17);
    check("s1_gnt_overlap", n_both - b_both, 0);
    check("s1_cmb_gnt_rise", cg_rise, c0 + 112);
    check("s1_dec_gnt_rise", dg_rise, c0 + 133);
    check("s1_mem_sel_rise", ms_rise, c0 + 133);
    check("s1_sb_empty", sb.size(), 0);
    o = outs(1'b0);
    check("s1_err", 32'(o[2]), 32'd0);
    check("s1_busy_after", 32'(o[3]), 32'd0);

    // Back-to-back single pixel, stray done/gray_valid during ORDER, no requests
    creq = 1'b0; dreq = 1'b0;
    b_en = n_cnt_en; b_clr = n_cnt_clr; b_cg = n_cmb_gnt; b_dg = n_dec_gnt; b_ms = n_mem_sel;
    run_flow(1'b0, 1, 3, 0, 0, 1'b1, fl(1, 3, 0, 0), -1);
    check("s2_cnt_en", n_cnt_en - b_en, 1);
    check("s2_cnt_clr", n_cnt_clr - b_clr, 1);
    check("s2_cmb_gnt", n_cmb_gnt - b_cg, 0);
    check("s2_dec_gnt", n_dec_gnt - b_dg, 0);
    check("s2_mem_sel_cycles", n_mem_sel - b_ms, 2);
    check("s2_sb_empty", sb.size(), 0);

    // ord_done never comes: ERR TO cycles after ORDER entry, sticky, bursts ignored
    creq = 1'b1; dreq = 1'b1;
    run_flow(1'b0, 5, -1, -1, -1, 1'b0, 5 + 1 + TO + 2, 5 + 1 + TO);
    o = outs(1'b0);
    check("s3_err", 32'(o[2]), 32'd1);
    b_en = n_cnt_en; b_clr = n_cnt_clr; b_cg = n_cmb_gnt; b_dg = n_dec_gnt;
    run_flow(1'b0, 10, -1, -1, -1, 1'b0, 14, -2);
    o = outs(1'b0);
    check("s3_cnt_en_in_err", n_cnt_en - b_en, 0);
    check("s3_cnt_clr_in_err", n_cnt_clr - b_clr, 0);
    check("s3_gnt_in_err", (n_cmb_gnt - b_cg) + (n_dec_gnt - b_dg), 0);
    check("s3_err_sticky", 32'(o[2]), 32'd1);
    check("s3_busy", 32'(o[3]), 32'd1);
    check("s3_sb_empty", sb.size(), 0);
    reset = 1'b0;
    tick();
    check("s3_reset_outs", 32'(outs(1'b0)), 32'd0);
    reset = 1'b1;
    tick();

    // cmb_done on the last allowed cycle: done wins
    creq = 1'b0; dreq = 1'b0;
    run_flow(1'b0, 2, 0, TO - 1, 2, 1'b0, fl(2, 0, TO - 1, 2), -1);
    o = outs(1'b0);
    check("s4_err_coincide", 32'(o[2]), 32'd0);
    check("s4_sb_empty", sb.size(), 0);

    // cmb_done one cycle too late: ERR
    run_flow(1'b0, 2, 0, TO, 2, 1'b0, 2 + 1 + 0 + 1 + TO + 3, 2 + 1 + 0 + 1 + TO);
    o = outs(1'b0);
    check("s4_err_late", 32'(o[2]), 32'd1);
    check("s4b_sb_empty", sb.size(), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // CNT_W=4: 16 pixels overflow, 15 pixels run normally
    run_flow(1'b1, 16, -1, -1, -1, 1'b0, 20, 16);
    o = outs(1'b1);
    check("s5_ovf_err", 32'(o[2]), 32'd1);
    check("s5_ovf_sb_empty", sb.size(), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    b_en = n_cnt_en;
    run_flow(1'b1, 15, 1, 1, 1, 1'b0, fl(15, 1, 1, 1), -1);
    o = outs(1'b1);
    check("s5_15pix_err", 32'(o[2]), 32'd0);
    check("s5_15pix_cnt_en", n_cnt_en - b_en, 15);
    check("s5_15pix_sb_empty", sb.size(), 0);

    // Reset mid-COMB with the combiner granted
    creq = 1'b1; dreq = 1'b1;
    run_flow(1'b0, 3, 2, -1, -1, 1'b0, 9, -1);
    o = outs(1'b0);
    check("s6_cmb_gnt_before", 32'(o[6]), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("s6_async_reset_outs", 32'(outs(1'b0)), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("s6_sb_empty", sb.size(), 0);

    // Fresh burst after reset completes normally
    b_cg = n_cmb_gnt; b_dg = n_dec_gnt;
    run_flow(1'b0, 20, 1, 2, 3, 1'b0, fl(20, 1, 2, 3), -1);
    o = outs(1'b0);
    check("s7_err", 32'(o[2]), 32'd0);
    check("s7_cmb_gnt_cycles", n_cmb_gnt - b_cg, 3);
    check("s7_dec_gnt_cycles", n_dec_gnt - b_dg, 5);
    check("s7_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
